// File: rtl/lives_display.sv
// Per-player life counters with blink-on-hit invulnerability, plus a heart-row
// overlay renderer whose pixel output lags the (x,y) input by exactly one clock.

module heart_rom (
    input  logic        clk,
    input  logic [4:0]  row,
    input  logic [4:0]  col,
    output logic [11:0] data
);
    // Shaded sprite: strong red channel with row/col gradient in the low bits.
    always_ff @(posedge clk) begin
        data <= {2'b11, row, col};
    end
endmodule

module lives_display #(
    parameter int NUM_PLAYERS   = 2,
    parameter int MAX_LIVES     = 3,
    parameter int HEART_W       = 24,
    parameter int HEART_H       = 23,
    parameter int X_BASE        = 55,
    parameter int HEART_STRIDE  = 39,
    parameter int PLAYER_STRIDE = 457,
    parameter int HEART_Y       = 30,
    parameter int BLINK_FRAMES  = 60,
    parameter int BLINK_HALF    = 8,
    localparam int LW           = $clog2(MAX_LIVES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [NUM_PLAYERS-1:0]    lose_life,
    input  logic [NUM_PLAYERS-1:0]    add_life,
    input  logic                      restart,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    output logic [11:0]               rgb,
    output logic                      heart_on,
    output logic [NUM_PLAYERS*LW-1:0] lives,
    output logic                      game_over
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {ALIVE, BLINK, DEAD} state_e;

    state_e          state_q [NUM_PLAYERS];
    state_e          state_d [NUM_PLAYERS];
    logic [LW-1:0]   lives_q [NUM_PLAYERS];
    logic [LW-1:0]   lives_d [NUM_PLAYERS];
    logic [CW-1:0]   blink_q [NUM_PLAYERS];
    logic [CW-1:0]   blink_d [NUM_PLAYERS];

    logic            hit_d;
    logic            heart_on_q;
    logic [4:0]      row_d;
    logic [4:0]      col_d;
    logic [11:0]     rom_data;

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            state_d[p] = state_q[p];
            lives_d[p] = lives_q[p];
            blink_d[p] = blink_q[p];
            if (restart) begin
                state_d[p] = ALIVE;
                lives_d[p] = LW'(MAX_LIVES);
                blink_d[p] = '0;
            end else begin
                case (state_q[p])
                    ALIVE: begin
                        // A lose request always swallows a same-cycle add.
                        if (lose_life[p]) begin
                            if (lives_q[p] != '0) begin
                                lives_d[p] = lives_q[p] - 1'b1;
                                blink_d[p] = CW'(BLINK_FRAMES);
                                state_d[p] = BLINK;
                            end
                        end else if (add_life[p] && lives_q[p] < LW'(MAX_LIVES)) begin
                            lives_d[p] = lives_q[p] + 1'b1;
                        end
                    end
                    BLINK: begin
                        if (!lose_life[p] && add_life[p] && lives_q[p] < LW'(MAX_LIVES))
                            lives_d[p] = lives_q[p] + 1'b1;
                        if (frame_tick) begin
                            if (blink_q[p] > CW'(1)) begin
                                blink_d[p] = blink_q[p] - 1'b1;
                            end else begin
                                blink_d[p] = '0;
                                state_d[p] = (lives_d[p] == '0) ? DEAD : ALIVE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (reset) begin
                state_q[p] <= ALIVE;
                lives_q[p] <= LW'(MAX_LIVES);
                blink_q[p] <= '0;
            end else begin
                state_q[p] <= state_d[p];
                lives_q[p] <= lives_d[p];
                blink_q[p] <= blink_d[p];
            end
        end
    end

    // Priority scan: first visible heart in (player, heart) order wins.
    always_comb begin
        hit_d = 1'b0;
        row_d = '0;
        col_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int i = 0; i < MAX_LIVES; i++) begin
                automatic int  ox  = X_BASE + p * PLAYER_STRIDE + i * HEART_STRIDE;
                automatic logic vis = (i < int'(lives_q[p])) ||
                    (state_q[p] == BLINK && i == int'(lives_q[p]) &&
                     ((int'(blink_q[p]) / BLINK_HALF) % 2) == 0);
                automatic logic in_reg = int'(x) >= ox && int'(x) <= ox + HEART_W - 1 &&
                                         int'(y) >= HEART_Y && int'(y) <= HEART_Y + HEART_H - 1;
                if (!hit_d && vis && in_reg) begin
                    hit_d = 1'b1;
                    col_d = 5'(int'(x) - ox);
                    row_d = 5'(int'(y) - HEART_Y);
                end
            end
        end
    end

    heart_rom u_rom (
        .clk  (clk),
        .row  (row_d),
        .col  (col_d),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) heart_on_q <= 1'b0;
        else       heart_on_q <= hit_d;
    end

    assign heart_on = heart_on_q;
    assign rgb      = heart_on_q ? rom_data : 12'h000;

    always_comb begin
        lives     = '0;
        game_over = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            lives[p*LW +: LW] = lives_q[p];
            if (state_q[p] == DEAD) game_over = 1'b1;
        end
    end
endmodule

// File: tb/tb_lives_display.sv
// Directed and randomized checks of lives_display against a per-frame behavioural model.

module tb_lives_display;
    logic        clk = 1'b0;
    logic        reset, frame_tick, restart;
    logic [1:0]  lose_life, add_life;
    logic [9:0]  x, y;
    logic [11:0] rgb;
    logic        heart_on;
    logic [3:0]  lives;
    logic        game_over;

    int checks = 0;
    int failures = 0;

    // model: lives count, mode (0 alive, 1 blinking, 2 dead), frames left in blink
    int m_lives [2];
    int m_mode  [2];
    int m_left  [2];

    lives_display dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .lose_life(lose_life),
        .add_life(add_life), .restart(restart), .x(x), .y(y), .rgb(rgb),
        .heart_on(heart_on), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_pixel(input int px, input int py,
                                        output bit hit, output logic [11:0] col);
        hit = 0;
        col = 12'h000;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 3; i++) begin
                automatic int ox = 55 + p * 457 + i * 39;
                automatic bit vis = (i < m_lives[p]) ||
                                    (m_mode[p] == 1 && i == m_lives[p] && ((m_left[p] / 8) % 2) == 0);
                if (!hit && vis && px >= ox && px < ox + 24 && py >= 30 && py < 53) begin
                    hit = 1;
                    col = {2'b11, 5'(py - 30), 5'(px - ox)};
                end
            end
    endfunction

    function automatic void model_update();
        if (reset || restart) begin
            for (int p = 0; p < 2; p++) begin
                m_lives[p] = 3; m_mode[p] = 0; m_left[p] = 0;
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            automatic bit lo = lose_life[p];
            automatic bit ad = add_life[p];
            if (m_mode[p] == 0) begin
                if (lo && m_lives[p] > 0) begin
                    m_lives[p]--; m_left[p] = 60; m_mode[p] = 1;
                end else if (!lo && ad && m_lives[p] < 3) m_lives[p]++;
            end else if (m_mode[p] == 1) begin
                if (!lo && ad && m_lives[p] < 3) m_lives[p]++;
                if (frame_tick) begin
                    m_left[p]--;
                    if (m_left[p] == 0) m_mode[p] = (m_lives[p] == 0) ? 2 : 0;
                end
            end
        end
    endfunction

    // One clock: predict pixel from pre-edge state, advance model, check at negedge.
    task automatic tick();
        bit          e_hit;
        logic [11:0] e_rgb;
        model_pixel(int'(x), int'(y), e_hit, e_rgb);
        if (reset) begin e_hit = 0; e_rgb = 12'h000; end
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("heart_on", 32'(heart_on), 32'(e_hit));
        chk("rgb", 32'(rgb), 32'(e_rgb));
        chk("lives", 32'(lives), 32'({2'(m_lives[1]), 2'(m_lives[0])}));
        chk("game_over", 32'(game_over), 32'(m_mode[0] == 2 || m_mode[1] == 2));
        lose_life = '0; add_life = '0; restart = 0; frame_tick = 0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin frame_tick = 1; tick(); end
    endtask

    initial begin
        reset = 1; restart = 0; frame_tick = 0; lose_life = '0; add_life = '0;
        x = 10'd0; y = 10'd0;
        for (int p = 0; p < 2; p++) begin m_lives[p] = 3; m_mode[p] = 0; m_left[p] = 0; end
        tick(); tick();
        chk("reset_lives", 32'(lives), 32'hF);
        chk("reset_go", 32'(game_over), 0);
        chk("reset_on", 32'(heart_on), 0);
        chk("reset_rgb", 32'(rgb), 0);
        reset = 0;

        // Scan across heart 0 of player 0, including both edges.
        y = 10'd40;
        for (int xx = 55; xx <= 80; xx++) begin
            x = 10'(xx);
            tick();
            chk("scan_on", 32'(heart_on), 32'(xx <= 78));
        end

        // Lose one life; watch the lost heart blink then vanish.
        x = 10'd140;
        lose_life = 2'b01; tick();
        chk("lose0_lives", 32'(lives[1:0]), 2);
        frames(64);
        chk("blink_done_on", 32'(heart_on), 0);
        chk("blink_done_go", 32'(game_over), 0);

        // Repeated losses during the invulnerability window count once.
        lose_life = 2'b01; tick();
        for (int k = 0; k < 5; k++) begin lose_life = 2'b01; frame_tick = 1; tick(); end
        chk("invuln_lives", 32'(lives[1:0]), 1);
        frames(60);

        // Lose beats add; add saturates.
        restart = 1; tick();
        lose_life = 2'b01; add_life = 2'b01; tick();
        chk("lose_prio", 32'(lives[1:0]), 2);
        restart = 1; tick();
        add_life = 2'b11; tick();
        chk("add_sat", 32'(lives), 32'hF);

        // Drain player 1 to DEAD; add_life is then ignored.
        x = 10'd590;
        for (int k = 0; k < 3; k++) begin
            lose_life = 2'b10; tick();
            frames(61);
        end
        chk("dead_lives", 32'(lives[3:2]), 0);
        chk("dead_go", 32'(game_over), 1);
        add_life = 2'b10; tick();
        chk("dead_add", 32'(lives[3:2]), 0);

        // Restart mid-blink, then reset together with restart mid-blink.
        x = 10'd140;
        restart = 1; tick();
        lose_life = 2'b01; tick();
        frames(3);
        restart = 1; tick();
        chk("restart_lives", 32'(lives), 32'hF);
        chk("restart_go", 32'(game_over), 0);
        lose_life = 2'b11; tick();
        frames(2);
        reset = 1; restart = 1; lose_life = 2'b01; tick();
        reset = 0;
        chk("rst_restart_lives", 32'(lives), 32'hF);
        frames(10);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            x = 10'($urandom_range(40, 620));
            y = 10'($urandom_range(25, 58));
            for (int p = 0; p < 2; p++) begin
                lose_life[p] = ($urandom_range(0, 19) == 0);
                add_life[p]  = !lose_life[p] && ($urandom_range(0, 29) == 0);
            end
            frame_tick = 1'($urandom_range(0, 1));
            restart    = ($urandom_range(0, 299) == 0);
            reset      = ($urandom_range(0, 799) == 0);
            tick();
            reset = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lives_display.md
LIVES_DISPLAY -- requirements
Module: lives_display

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of independent life counters and heart rows.
REQ-002 SHALL have parameter MAX_LIVES, default 3, hearts per player and lives after reset or restart.
REQ-003 SHALL have parameters HEART_W 24 and HEART_H 23, the sprite size in pixels (each at most 32).
REQ-004 SHALL have parameters X_BASE 55, HEART_STRIDE 39, PLAYER_STRIDE 457 and HEART_Y 30, the screen placement.
REQ-005 SHALL have parameters BLINK_FRAMES 60 and BLINK_HALF 8, the blink duration and half-period in frames.
REQ-006 clk  input  1  pixel clock; the only clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 lose_life  input  NUM_PLAYERS  per-player one-cycle decrement request.
REQ-010 add_life  input  NUM_PLAYERS  per-player one-cycle increment request.
REQ-011 restart  input  1  one-cycle restore of all players to MAX_LIVES.
REQ-012 x, y  input  10 each  current pixel coordinate.
REQ-013 rgb  output  12  heart pixel colour, registered.
REQ-014 heart_on  output  1  heart pixel valid, registered.
REQ-015 lives  output  NUM_PLAYERS*LW  packed life counts, with LW = clog2(MAX_LIVES+1) and player 0 in the LSBs.
REQ-016 game_over  output  1  asserted while any player is in DEAD.

Function
REQ-017 Each player SHALL run an FSM with the states ALIVE, BLINK and DEAD, plus a lives counter and a blink counter.
REQ-018 In ALIVE, lose_life[p] with lives>0 SHALL decrement lives on the next edge, load blink_cnt=BLINK_FRAMES and enter BLINK.
REQ-019 In BLINK, each frame_tick SHALL decrement blink_cnt; when it reaches 0 the FSM SHALL go to DEAD if lives==0, else to ALIVE.
REQ-020 lose_life[p] in BLINK or DEAD SHALL be ignored; BLINK acts as an invulnerability window.
REQ-021 add_life[p] in ALIVE or BLINK SHALL increment lives, saturating at MAX_LIVES, and SHALL be ignored in DEAD.
REQ-022 When lose_life[p] and add_life[p] arrive in the same cycle, lose SHALL take priority and the add SHALL be dropped.
REQ-023 restart SHALL override all requests in its cycle, setting every player to lives=MAX_LIVES, ALIVE, blink_cnt=0.
REQ-024 Heart i of player p SHALL occupy origin ox = X_BASE + p*PLAYER_STRIDE + i*HEART_STRIDE, with ox <= x <= ox+HEART_W-1 and HEART_Y <= y <= HEART_Y+HEART_H-1 (inclusive).
REQ-025 Heart i SHALL be visible when i < lives.
REQ-026 In BLINK, heart i == lives (the heart just lost) SHALL also be visible while (blink_cnt / BLINK_HALF) is even.
REQ-027 When heart regions overlap, the lowest player index SHALL win, then the lowest heart index.
REQ-028 Sprite pixels SHALL come from one shared heart_rom using row = y-HEART_Y and col = x-ox (5 bits each), with one-cycle synchronous read.
REQ-029 Visibility and hit decode SHALL be registered one stage, so that rgb and heart_on for pixel (x,y) appear exactly 1 clk after (x,y).
REQ-030 When no heart is hit, rgb SHALL be 12'h000 and heart_on SHALL be 0.
REQ-031 The sprite geometry SHALL be fixed: a pixel inside a visible heart region SHALL assert heart_on regardless of ROM colour.
REQ-032 game_over SHALL be combinational from the FSM states, with no extra latency.

Reset
REQ-033 On reset, every player SHALL go to lives=MAX_LIVES, ALIVE, blink_cnt=0.
REQ-034 On reset, rgb SHALL be 0, heart_on SHALL be 0 and game_over SHALL be 0.
REQ-035 Reset SHALL take priority over restart and over every request, including mid-BLINK.

Verification
REQ-036 Reset, then scan x=55..80 at y=40 -> heart_on=1 for x=55..78, observed 1 clk later; lives=3,3; game_over=0.
REQ-037 lose_life[0] pulse -> lives[0]=2 next cycle; heart 2 of player 0 (x=133..156) toggles every 8 frames and vanishes after 60 frame_ticks.
REQ-038 Three lose_life[1] pulses, each 61 frames apart -> lives[1]=0, then DEAD after the last blink, game_over=1; add_life[1] is then ignored.
REQ-039 lose_life[0] repeated during BLINK -> lives[0] decremented once only.
REQ-040 lose_life[0] and add_life[0] in the same cycle at lives=3 -> lives=2; add_life at lives=3 -> stays 3.
REQ-041 restart mid-BLINK, and reset asserted during restart -> all lives=3, ALIVE, game_over=0, blink stops next cycle.
